bus_owner_arbiter: RTL and testbench
====================================

# bus_owner_arbiter

Round-robin arbiter that shares the processor's single internal data bus among up to eight bus drivers (PC, IR immediate, register file, ALU, memory, etc.). It owns the bus-source mux select. It grants exactly one driver at a time, bounds ownership with a hold limit, and inserts one dead turnaround cycle between owners. It sits between the microcode sequencer's per-driver enable requests and the bus-source 8:1 mux.

## Interface
- NUM_REQ, 8, number of requesters; fixed at 8 in this revision.
- SEL_WIDTH, 3, width of the mux select; equals clog2(NUM_REQ).
- MAX_HOLD, 15, consecutive cycles an unlocked owner may keep the bus while others wait; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  NUM_REQ  per-driver bus request; level, held until served.
- lock  input  NUM_REQ  per-driver lock; when set for the current owner, it blocks preemption.
- grant  output  NUM_REQ  registered one-hot grant; all zeros when the bus is not owned.
- sel  output  SEL_WIDTH  registered bus-mux select; index of the current or most recent owner.
- bus_valid  output  1  registered; high when grant is non-zero.
- preempt  output  1  registered one-cycle pulse when an owner is forcibly released by the hold limit.

## Operation
- States: IDLE, OWN, TURN.
- Reset values: state=IDLE, grant=0, sel=0, bus_valid=0, preempt=0, last_owner=NUM_REQ-1, hold_cnt=0.
- Pick rule: search req starting at (last_owner+1) mod NUM_REQ upward with wrap-around. The first set bit wins.
- IDLE: if any req is set, go to OWN. Set grant to the winner, sel to the winner's index, last_owner to the winner, and hold_cnt to 0. Otherwise stay in IDLE.
- OWN, owner's req low: go to TURN with grant=0. sel is unchanged.
- OWN, owner's req high, hold_cnt reaches MAX_HOLD-1, lock[owner]=0, and another req is pending: go to TURN and assert preempt for that one cycle.
- OWN, otherwise: stay in OWN. hold_cnt increments and saturates at MAX_HOLD-1. It does not increment while no other req is pending.
- TURN: grant=0 for exactly one cycle. Then apply the IDLE rules. If no req is pending, go to IDLE.
- A preempted owner that still requests competes normally. Round-robin places it last.
- lock without req has no effect. lock on a non-owner is ignored.
- Simultaneous release and new request in the same cycle: the release wins. TURN is still inserted.
- rst_n asserted mid-ownership: all outputs go to their reset values immediately (asynchronously). Arbitration restarts with requester 0 first.

## Timing
- Request to grant latency from IDLE: 1 cycle. req sampled high at edge N gives grant valid after edge N.
- Owner handover: owner req low at edge N, TURN after edge N, new grant after edge N+1. There is exactly one gap cycle.
- Preemption: after MAX_HOLD contested cycles of grant, grant falls at the following edge.
- Outputs are purely registered. There is no combinational path from req or lock to any output.
- sel holds its last value through TURN and IDLE, so the mux output stays stable while bus_valid=0.

## Structure
- Shared package bus_arb_pkg holds the state enum (IDLE, OWN, TURN), NUM_REQ, SEL_WIDTH, and the default MAX_HOLD constant.
- One sub-module, rr_pick: combinational rotate-and-find-first.
  - Inputs: req and the start index.
  - Outputs: winner index and any_req.
  - It is instantiated once and reused by the IDLE and TURN paths.
- The top level holds the FSM, last_owner, hold_cnt, and output registers.

## Test plan
- Reset, then req=8'b0000_0001 → after one edge grant=8'h01, sel=0, bus_valid=1. Drop req → one cycle grant=0, then IDLE.
- Round-robin: req=8'hFF constant, each owner releases after 1 cycle → grant order 01,02,04,…,80,01 with one zero cycle between each.
- Preemption: MAX_HOLD=4, req=8'h09, owner 0 unlocked, holds req → grant 01 for 4 cycles, preempt=1 for one cycle, then grant=08.
- Lock: same as above with lock=8'h01 → grant stays 01 past 4 cycles and preempt stays 0. Lock drop → preemption at the next edge.
- Async reset mid-OWN with grant=8'h20: drop rst_n between edges → grant=0, sel=0, bus_valid=0 immediately. After release with req=8'h21 → requester 0 is granted first.
- Single requester owning uncontested for 300 cycles → no preempt, hold_cnt does not wrap, grant stays stable.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the internal data-bus owner arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_REQ       = 8;
  localparam int unsigned SEL_WIDTH     = $clog2(NUM_REQ);
  localparam int unsigned MAX_HOLD_DFLT = 15;
  localparam int unsigned HOLD_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [SEL_WIDTH-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Index following idx, wrapping at NUM_REQ.
  function automatic logic [SEL_WIDTH-1:0] idx_next(input logic [SEL_WIDTH-1:0] idx);
    return SEL_WIDTH'((32'(idx) + 32'd1) % NUM_REQ);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-find-first: first set request at or after start, with wrap.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] start,
  output logic [SEL_WIDTH-1:0] winner,
  output logic                 any_req
);

  logic [SEL_WIDTH-1:0] idx;

  // Walk the requests in priority order starting at start; first hit wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = SEL_WIDTH'((32'(start) + i) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for the shared internal data bus, with hold
// limit, per-owner lock and one dead turnaround cycle between owners.
module bus_owner_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 bus_valid,
  output logic                 preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_e           state, state_d;
  logic [SEL_WIDTH-1:0] last_owner, last_owner_d;
  logic [HOLD_W-1:0]    hold_cnt, hold_cnt_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [SEL_WIDTH-1:0] sel_d;
  logic                 preempt_d;

  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_any;
  logic                 others_pending;

  // Shared picker for the IDLE and TURN paths; search starts after last owner.
  rr_pick u_pick (
    .req     (req),
    .start   (idx_next(last_owner)),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  // Someone other than the current owner wants the bus.
  assign others_pending = |(req & ~idx_onehot(last_owner));

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state;
    grant_d      = '0;
    sel_d        = sel;
    preempt_d    = 1'b0;
    last_owner_d = last_owner;
    hold_cnt_d   = hold_cnt;
    unique case (state)
      IDLE, TURN: begin
        if (pick_any) begin
          state_d      = OWN;
          grant_d      = idx_onehot(pick_idx);
          sel_d        = pick_idx;
          last_owner_d = pick_idx;
          hold_cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        grant_d = grant;
        if (!req[last_owner]) begin
          state_d = TURN;
          grant_d = '0;
        end else if (others_pending && (hold_cnt == HOLD_LIM) && !lock[last_owner]) begin
          state_d   = TURN;
          grant_d   = '0;
          preempt_d = 1'b1;
        end else if (others_pending && (hold_cnt != HOLD_LIM)) begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      sel        <= '0;
      bus_valid  <= 1'b0;
      preempt    <= 1'b0;
      last_owner <= SEL_WIDTH'(NUM_REQ - 1);
      hold_cnt   <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      sel        <= sel_d;
      bus_valid  <= |grant_d;
      preempt    <= preempt_d;
      last_owner <= last_owner_d;
      hold_cnt   <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Scoreboard bench for bus_owner_arbiter (built with MAX_HOLD=4).
module tb_bus_owner_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] lock = 8'h00;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       bus_valid;
  logic       preempt;

  typedef struct {
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bus_owner_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .sel       (sel),
    .bus_valid (bus_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic cycle(input logic [7:0] r, input logic [7:0] l,
                       input logic [7:0] eg, input logic [2:0] es,
                       input logic ev, input logic ep);
    exp_t e;
    exp_t got_e;
    req  = r;
    lock = l;
    e.g = eg; e.s = es; e.v = ev; e.p = ep;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      got_e = exp_q.pop_front();
      check_eq("grant", 32'(grant), 32'(got_e.g));
      check_eq("sel", 32'(sel), 32'(got_e.s));
      check_eq("bus_valid", 32'(bus_valid), 32'(got_e.v));
      check_eq("preempt", 32'(preempt), 32'(got_e.p));
    end
  endtask

  task automatic do_reset();
    req   = 8'h00;
    lock  = 8'h00;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_sel", 32'(sel), 32'h0);
    check_eq("rst_valid", 32'(bus_valid), 32'h0);
    check_eq("rst_preempt", 32'(preempt), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;
    logic [2:0] k;

    // Single request: one-cycle latency, release, turnaround, idle.
    do_reset();
    cycle(8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);
    cycle(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    cycle(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // Round-robin across all eight with a dead cycle between owners.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      k  = 3'(i);
      oh = 8'h01 << k;
      cycle(8'hFF, 8'h00, oh, k, 1'b1, 1'b0);
      cycle(8'hFF & ~oh, 8'h00, 8'h00, k, 1'b0, 1'b0);
    end
    cycle(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // Preemption by the hold limit, then the waiting driver, then back.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(8'h09, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);
    cycle(8'h09, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    cycle(8'h09, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0);
    cycle(8'h01, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    cycle(8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);
    cycle(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // Lock holds the bus past the limit; dropping it preempts at the next edge.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(8'h09, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    cycle(8'h09, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    cycle(8'h09, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0);
    cycle(8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);

    // Lock on a non-owner is ignored.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(8'h09, 8'h08, 8'h01, 3'd0, 1'b1, 1'b0);
    cycle(8'h09, 8'h08, 8'h00, 3'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of ownership.
    do_reset();
    cycle(8'h20, 8'h00, 8'h20, 3'd5, 1'b1, 1'b0);
    cycle(8'h20, 8'h00, 8'h20, 3'd5, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_grant", 32'(grant), 32'h0);
    check_eq("async_sel", 32'(sel), 32'h0);
    check_eq("async_valid", 32'(bus_valid), 32'h0);
    #1;
    rst_n = 1'b1;
    cycle(8'h21, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0);
    cycle(8'h20, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    cycle(8'h20, 8'h00, 8'h20, 3'd5, 1'b1, 1'b0);

    // Long uncontested ownership, then contention starts the hold count.
    do_reset();
    for (int i = 0; i < 301; i++) cycle(8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(8'h0C, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0);
    cycle(8'h0C, 8'h00, 8'h00, 3'd2, 1'b0, 1'b1);
    cycle(8'h0C, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
